// File: rtl/muldiv_if.sv
// Request/response bundle of the RV M-extension multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic            word_i;
    logic [XLEN-1:0] operand1_i;
    logic [XLEN-1:0] operand2_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            busy_o;

    modport slave (
        input  valid_i, funct3_i, word_i, operand1_i, operand2_i, rd_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, rd_o, busy_o
    );

    modport master (
        output valid_i, funct3_i, word_i, operand1_i, operand2_i, rd_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, rd_o, busy_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide unit: radix-2^MUL_STEP shift-add
// multiplier and restoring radix-2 divider sharing one 2*XLEN accumulator.
// Both work on operand magnitudes; the sign is restored on the final step.
module muldiv_unit #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 4
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CW    = $clog2(XLEN);
    localparam int MITER = XLEN / MUL_STEP;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state, state_d;
    logic [2*XLEN-1:0] acc;       // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]   mcand;     // |multiplicand| or |divisor|
    logic [XLEN-1:0]   res_q;
    logic [CW-1:0]     cnt;       // remaining iterations - 1
    logic [2:0]        f3_q;
    logic              word_q, negq_q, negr_q;
    logic [4:0]        rd_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] t;
        t = x;
        return XLEN'(t);
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] x, input logic w);
        return w ? sext32(x[31:0]) : x;
    endfunction

    // Operand preparation from the request; only consumed on the accept edge.
    logic            a_sgn, b_sgn, a_neg, b_neg, accept, special, div_zero, div_ovf, last;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_res;

    assign accept = bus.valid_i && (state == IDLE) && !bus.flush_i;
    // rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MUL/MULH/DIV/REM
    assign a_sgn  = bus.funct3_i[2] ? !bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'd3);
    assign b_sgn  = bus.funct3_i[2] ? !bus.funct3_i[0] : !bus.funct3_i[1];
    assign a_ext  = !bus.word_i ? bus.operand1_i :
                    a_sgn ? sext32(bus.operand1_i[31:0]) : XLEN'(bus.operand1_i[31:0]);
    assign b_ext  = !bus.word_i ? bus.operand2_i :
                    b_sgn ? sext32(bus.operand2_i[31:0]) : XLEN'(bus.operand2_i[31:0]);
    assign a_neg  = a_sgn && a_ext[XLEN-1];
    assign b_neg  = b_sgn && b_ext[XLEN-1];
    assign a_mag  = a_neg ? -a_ext : a_ext;
    assign b_mag  = b_neg ? -b_ext : b_ext;

    assign min_val  = bus.word_i ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = (b_ext == '0);
    assign div_ovf  = a_sgn && (b_ext == '1) && (a_ext == min_val);
    assign special  = bus.funct3_i[2] && (div_zero || div_ovf);
    assign spec_res = fmt(div_zero ? (bus.funct3_i[1] ? a_ext : '1)
                                   : (bus.funct3_i[1] ? '0 : a_ext), bus.word_i);

    // One iteration of the multiplier or divider.
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [XLEN:0]            rem_sh, trial;
    logic [2*XLEN-1:0]        mul_nxt, div_nxt, step_nxt, prod_s;
    logic [XLEN-1:0]          quo_s, rem_s, fin_res;

    assign mul_sum  = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]}
                    + (XLEN+MUL_STEP)'(mcand) * (XLEN+MUL_STEP)'(acc[MUL_STEP-1:0]);
    assign mul_nxt  = {mul_sum, acc[XLEN-1:MUL_STEP]};
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign trial    = rem_sh - {1'b0, mcand};
    assign div_nxt  = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign step_nxt = (state == MUL) ? mul_nxt : div_nxt;
    assign last     = (cnt == '0);

    // Sign restoration and result selection on the last iteration.
    always_comb begin
        prod_s  = negq_q ? -step_nxt : step_nxt;
        quo_s   = negq_q ? -step_nxt[XLEN-1:0] : step_nxt[XLEN-1:0];
        rem_s   = negr_q ? -step_nxt[2*XLEN-1:XLEN] : step_nxt[2*XLEN-1:XLEN];
        fin_res = '0;
        if (state == MUL)
            fin_res = fmt((f3_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN], word_q);
        else
            fin_res = fmt(f3_q[1] ? rem_s : quo_s, word_q);
    end

    // Next-state logic; flush overrides accept and the output handshake.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (accept)
                      state_d = !bus.funct3_i[2] ? MUL : (special ? DONE : DIV);
            MUL,
            DIV:  if (last) state_d = DONE;
            DONE: if (bus.ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            res_q  <= '0;
            cnt    <= '0;
            f3_q   <= '0;
            word_q <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            rd_q   <= '0;
        end else if (accept) begin
            f3_q   <= bus.funct3_i;
            word_q <= bus.word_i;
            rd_q   <= bus.rd_i;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            mcand  <= bus.funct3_i[2] ? b_mag : a_mag;
            // word divides pre-shift the dividend so 32 steps consume it
            acc    <= {{XLEN{1'b0}}, !bus.funct3_i[2] ? b_mag :
                                     bus.word_i ? (a_mag << 32) : a_mag};
            cnt    <= !bus.funct3_i[2] ? CW'(MITER-1) : bus.word_i ? CW'(31) : CW'(XLEN-1);
            if (special) res_q <= spec_res;
        end else if (state == MUL || state == DIV) begin
            acc <= step_nxt;
            cnt <= cnt - CW'(1);
            if (last) res_q <= fin_res;
        end
    end

    assign bus.ready_o  = (state == IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.busy_o   = (state != IDLE);
    assign bus.result_o = res_q;
    assign bus.rd_o     = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit with an expected-result scoreboard.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.XLEN(64)) bus ();
    muldiv_unit #(.XLEN(64), .MUL_STEP(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] eff(input logic [63:0] x, input logic w, input logic sgn);
        if (!w) return x;
        return sgn ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
    endfunction

    // Reference result from wide-integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic               sa, sb_;
        logic [63:0]        ea, eb, r64;
        logic [127:0]       aa, bb, p;
        logic signed [127:0] q, r;
        sa  = f[2] ? !f[0] : (f[1:0] != 2'd3);
        sb_ = f[2] ? !f[0] : !f[1];
        ea  = eff(a, w, sa);
        eb  = eff(b, w, sb_);
        aa  = sa  ? {{64{ea[63]}}, ea} : {64'b0, ea};
        bb  = sb_ ? {{64{eb[63]}}, eb} : {64'b0, eb};
        if (!f[2]) begin
            p   = aa * bb;
            r64 = (f == 3'd0) ? p[63:0] : p[127:64];
        end else begin
            if (bb == '0) begin
                q = '1;
                r = aa;
            end else begin
                q = $signed(aa) / $signed(bb);
                r = $signed(aa) % $signed(bb);
            end
            r64 = f[1] ? r[63:0] : q[63:0];
        end
        return w ? {{32{r64[31]}}, r64[31:0]} : r64;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ea, eb;
        if (!f[2]) return 17;
        ea = eff(a, w, !f[0]);
        eb = eff(b, w, !f[0]);
        if (eb == '0) return 1;
        if (!f[0] && eb == '1 && ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
            return 1;
        return w ? 33 : 65;
    endfunction

    // Wait for ready, then present one request for a single accept edge.
    task automatic drive(input logic [2:0] f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        while (!bus.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 64'(bus.ready_o), 64'd1);
        bus.funct3_i = f; bus.word_i = w; bus.operand1_i = a; bus.operand2_i = b;
        bus.rd_i = rd; bus.valid_i = 1'b1;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp, input int lat);
        exp_t e;
        drive(f, w, a, b, rd);
        e.tag = tag; e.res = exp; e.rd = rd; e.lat = lat;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation, wait for valid_o, check, optionally stall, then retire.
    task automatic collect(input int hold);
        exp_t e;
        int   k = 0;
        e = sb.pop_front();
        do begin
            @(negedge clk);
            k++;
        end while (!bus.valid_o && k < 200);
        chk({e.tag, "_lat"}, 64'(k), 64'(e.lat));
        chk({e.tag, "_res"}, bus.result_o, e.res);
        chk({e.tag, "_rd"}, 64'(bus.rd_o), 64'(e.rd));
        for (int i = 0; i < hold; i++) begin
            bus.valid_i = (i >= 3 && i < 6);
            bus.funct3_i = 3'd4; bus.word_i = 1'b0;
            bus.operand1_i = 64'd100; bus.operand2_i = 64'd0; bus.rd_i = 5'd31;
            @(negedge clk);
            chk({e.tag, "_hold_res"}, bus.result_o, e.res);
            chk({e.tag, "_hold_rd"}, 64'(bus.rd_o), 64'(e.rd));
            chk({e.tag, "_hold_ready"}, 64'(bus.ready_o), 64'd0);
            chk({e.tag, "_hold_valid"}, 64'(bus.valid_o), 64'd1);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1 bus.ready_i = 1'b0;
        chk({e.tag, "_idle"}, 64'(bus.ready_o), 64'd1);
        chk({e.tag, "_novalid"}, 64'(bus.valid_o), 64'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic        w;
        logic [63:0] a, b;
        int          seen;

        rst = 1'b1;
        bus.valid_i = 1'b0; bus.funct3_i = '0; bus.word_i = 1'b0; bus.operand1_i = '0;
        bus.operand2_i = '0; bus.rd_i = '0; bus.flush_i = 1'b0; bus.ready_i = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_rd", 64'(bus.rd_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue("mulh", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 17);
        collect(0);
        issue("mulhu", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd6, 64'h2, 17);
        collect(0);
        issue("div", 3'd4, 1'b0, -64'sd7, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        collect(0);
        issue("rem", 3'd6, 1'b0, -64'sd7, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        collect(0);
        issue("divuw", 3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 5'd9, 64'h0000_0000_7FFF_FFFF, 33);
        collect(0);
        issue("div0", 3'd4, 1'b0, 64'd123, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        collect(0);
        issue("remu0", 3'd7, 1'b0, 64'd9, 64'd0, 5'd11, 64'd9, 1);
        collect(0);
        issue("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd12, 64'h8000_0000_0000_0000, 1);
        collect(0);
        issue("removf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd13, 64'd0, 1);
        collect(0);
        issue("mulhsu", 3'd2, 1'b0, '1, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 17);
        collect(0);
        issue("remw", 3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        collect(0);

        // Backpressure: result parked for 10 cycles with stray requests.
        issue("bp_mul", 3'd0, 1'b0, 64'd6, 64'd7, 5'd3, 64'd42, 17);
        collect(10);

        // Flush mid-divide: unit must go idle and never present a result.
        drive(3'd4, 1'b0, 64'd1000, 64'd3, 5'd20);
        repeat (5) @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        chk("flush_ready", 64'(bus.ready_o), 64'd1);
        chk("flush_busy", 64'(bus.busy_o), 64'd0);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        chk("flush_novalid", 64'(seen), 64'd0);
        issue("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd21, 64'hFFFF_FFFF_FFFF_FFFE, 17);
        collect(0);

        // Reset pulse mid-multiply: outputs clear at once, op abandoned.
        drive(3'd0, 1'b0, 64'd5, 64'd5, 5'd22);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_valid", 64'(bus.valid_o), 64'd0);
        chk("mrst_busy", 64'(bus.busy_o), 64'd0);
        chk("mrst_ready", 64'(bus.ready_o), 64'd1);
        chk("mrst_result", bus.result_o, 64'd0);
        chk("mrst_rd", 64'(bus.rd_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mrst_ready_after", 64'(bus.ready_o), 64'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        chk("mrst_novalid", 64'(seen), 64'd0);

        // Random ops against the wide-arithmetic model.
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            w = (f == 3'd0 || f[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 1) b = 64'($urandom_range(1, 50));
            if (i % 4 == 3) b = '0;
            issue($sformatf("rnd%0d", i), f, w, a, b, 5'(i), ref_model(f, w, a, b),
                  ref_lat(f, w, a, b));
            collect(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 64, sets the operand/result width (legal values 32, 64).
REQ-002 Parameter MUL_STEP, default 4, sets the multiplier bits retired per cycle (power of 2, divides XLEN).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is an asynchronous, active-high reset.
REQ-005 Port valid_i  input  1  marks a request present.
REQ-006 Port ready_o  output  1  means the unit can accept a request.
REQ-007 Port funct3_i  input  3  selects the RV M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 Port word_i  input  1  selects the W variant (MULW/DIVW/DIVUW/REMW/REMUW); it is only legal when XLEN=64.
REQ-009 Port operand1_i  input  XLEN  is rs1.
REQ-010 Port operand2_i  input  XLEN  is rs2.
REQ-011 Port rd_i  input  5  is the destination tag, carried to rd_o.
REQ-012 Port flush_i  input  1  kills any in-flight or pending operation.
REQ-013 Port valid_o  output  1  marks result_o/rd_o valid.
REQ-014 Port ready_i  input  1  is the consumer's acceptance signal.
REQ-015 Port result_o  output  XLEN  is the result.
REQ-016 Port rd_o  output  5  is the tag of the result.
REQ-017 Port busy_o  output  1  is high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, MUL, DIV, DONE; ready_o = (state==IDLE) and valid_o = (state==DONE).
REQ-019 A request SHALL be accepted on a clock edge where valid_i && ready_o && !flush_i; the operands, funct3, word and rd SHALL be latched on that edge.
REQ-020 On accept of funct3 0-3: IDLE->MUL; the unit retires MUL_STEP multiplier bits per cycle for XLEN/MUL_STEP cycles, then moves to DONE. valid_o SHALL rise XLEN/MUL_STEP+1 cycles after accept (17 cycles at the defaults).
REQ-021 On accept of funct3 4-7 with no special case: IDLE->DIV; a restoring radix-2 divide runs for N cycles (N=32 if word, else XLEN), then DONE. valid_o SHALL rise N+1 cycles after accept.
REQ-022 Division special cases SHALL bypass the DIV state (IDLE->DONE, valid_o one cycle after accept):
- divide by zero: quotient = all ones; remainder = dividend.
- signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- the operand widths are those of the effective op (32-bit when word).
REQ-023 Signedness rules:
- MUL/MULH use signed x signed.
- MULHSU uses signed rs1 x unsigned rs2.
- MULHU uses unsigned x unsigned.
- MUL returns the low XLEN bits of the 2*XLEN product; MULH* return the high XLEN bits.
- DIV/REM use signed operands: the quotient truncates toward zero and the remainder takes the sign of the dividend.
- DIVU/REMU use unsigned operands.
REQ-024 W ops SHALL use only operand[31:0] (sign- or zero-extended per op), produce a 32-bit result and sign-extend bit 31 to XLEN.
REQ-025 In DONE, result_o and rd_o SHALL hold stable until ready_i; DONE->IDLE on the edge with ready_i=1. A new request cannot be accepted in that same cycle, so throughput is one op per latency+1 cycles.
REQ-026 flush_i=1 in any state SHALL force IDLE on the next edge with valid_o=0 and the result discarded; flush_i has priority over both accept and ready_i.
REQ-027 result_o SHALL be driven only from registered state; there is no combinational path from operand inputs to result_o.

Reset
REQ-028 While rst=1 (asynchronously):
- state=IDLE, valid_o=0, busy_o=0, ready_o=1, result_o=0, rd_o=0.
- all internal accumulators and counters are 0.
REQ-029 Reset asserted mid-operation SHALL abandon the op; no result appears after rst deasserts.

Verification
REQ-030 MULH, XLEN=64, op1=-2 (0xFFFF_FFFF_FFFF_FFFE), op2=3, rd=5 -> after 17 cycles valid_o=1, result_o=0xFFFF_FFFF_FFFF_FFFF, rd_o=5; MULHU with the same operands -> result_o=0x2.
REQ-031 DIV op1=-7, op2=2 -> result -3 after 65 cycles; REM with the same operands -> -1; DIVUW op1=0xFFFF_FFFF, op2=2 -> 0x0000_0000_7FFF_FFFF after 33 cycles.
REQ-032 Special cases, each with valid_o one cycle after accept:
- DIV op2=0 -> 0xFFFF_FFFF_FFFF_FFFF.
- REMU op1=9, op2=0 -> 9.
- DIV op1=0x8000_0000_0000_0000, op2=-1 -> 0x8000_0000_0000_0000; REM with the same operands -> 0.
REQ-033 Backpressure: hold ready_i=0 for 10 cycles in DONE -> result_o/rd_o stable and ready_o=0 throughout; valid_i pulses during that window are not accepted.
REQ-034 Flush at cycle 5 of a DIV -> IDLE next cycle, valid_o never rises; a MULW with op1=0x7FFF_FFFF, op2=2 issued next -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-035 Assert rst for 1 cycle mid-MUL -> all outputs at reset values immediately; ready_o=1 after release.
